// File: rtl/lane_dly_train_ctrl.sv
// Delay-line training initiator for a DDR4 lane: steps or sweeps a tap delay line,
// brackets every tap change with a clock pause, and probes reads to find a passing tap.
module lane_dly_train_ctrl #(
  parameter int TAP_W         = 8,
  parameter int SETTLE_CYCLES = 8,
  parameter int PRE_CYCLES    = 2,
  parameter int READ_WAIT     = 16
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             MODE,
  input  logic             SEL_IN,
  input  logic             DIR_IN,
  input  logic [TAP_W-1:0] NUM_TAPS,
  input  logic             RX_BURST_DETECT,
  input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic             TX_DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_SEL,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_MOVE,
  output logic             HS_IO_CLK_PAUSE,
  output logic             DDR_READ,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [1:0]       ERR_CODE,
  output logic [TAP_W-1:0] TAP_COUNT,
  output logic [TAP_W-1:0] PASS_TAP,
  output logic [2:0]       dbg_state
);

  // Request handshake: START is a one-cycle request accepted only in IDLE (BUSY=0);
  // BUSY rises on the following cycle and falls on the same edge DONE pulses.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRE, S_MOVE, S_SETTLE, S_RD_ISSUE, S_RD_WAIT, S_FINISH
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] PRE_LAST    = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST   = CNT_W'(READ_WAIT - 1);
  localparam logic [TAP_W-1:0] TAP_MAX     = '1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [TAP_W-1:0]   num_q;
  logic [TAP_W-1:0]   steps_left;
  logic               mode_q;
  logic               load_pend;
  logic               oor;

  // SEL/DIRECTION registers double as the latched request fields.
  assign oor       = DELAY_LINE_SEL ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
  assign dbg_state = state;

  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      state                <= S_IDLE;
      cnt                  <= '0;
      num_q                <= '0;
      steps_left           <= '0;
      mode_q               <= 1'b0;
      load_pend            <= 1'b0;
      DELAY_LINE_SEL       <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
      DELAY_LINE_MOVE      <= 1'b0;
      HS_IO_CLK_PAUSE      <= 1'b0;
      DDR_READ             <= 1'b0;
      BUSY                 <= 1'b0;
      DONE                 <= 1'b0;
      ERROR                <= 1'b0;
      ERR_CODE             <= 2'b00;
      TAP_COUNT            <= '0;
      PASS_TAP             <= '0;
    end else begin
      DELAY_LINE_LOAD <= 1'b0;
      DELAY_LINE_MOVE <= 1'b0;
      DDR_READ        <= 1'b0;
      DONE            <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            DELAY_LINE_SEL       <= MODE ? 1'b0 : SEL_IN;
            DELAY_LINE_DIRECTION <= MODE ? 1'b1 : DIR_IN;
            num_q                <= NUM_TAPS;
            steps_left           <= NUM_TAPS;
            mode_q               <= MODE;
            load_pend            <= MODE;
            ERROR                <= 1'b0;
            ERR_CODE             <= 2'b00;
            BUSY                 <= 1'b1;
            cnt                  <= '0;
            if (!MODE && NUM_TAPS == '0) begin
              state <= S_FINISH;
            end else begin
              state           <= S_PRE;
              HS_IO_CLK_PAUSE <= 1'b1;
            end
          end
        end
        S_PRE: begin
          if (cnt == PRE_LAST) begin
            cnt <= '0;
            if (load_pend) begin
              state           <= S_LOAD;
              load_pend       <= 1'b0;
              DELAY_LINE_LOAD <= 1'b1;
            end else begin
              state           <= S_MOVE;
              DELAY_LINE_MOVE <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LOAD: begin
          TAP_COUNT <= '0;
          cnt       <= '0;
          state     <= S_SETTLE;
        end
        S_MOVE: begin
          if (DELAY_LINE_DIRECTION) begin
            if (TAP_COUNT != TAP_MAX) TAP_COUNT <= TAP_COUNT + 1'b1;
          end else begin
            if (TAP_COUNT != '0) TAP_COUNT <= TAP_COUNT - 1'b1;
          end
          if (steps_left != '0) steps_left <= steps_left - 1'b1;
          cnt   <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (oor) begin
              ERROR           <= 1'b1;
              ERR_CODE        <= 2'b01;
              HS_IO_CLK_PAUSE <= 1'b0;
              state           <= S_FINISH;
            end else if (mode_q) begin
              HS_IO_CLK_PAUSE <= 1'b0;
              DDR_READ        <= 1'b1;
              state           <= S_RD_ISSUE;
            end else if (steps_left == '0) begin
              HS_IO_CLK_PAUSE <= 1'b0;
              state           <= S_FINISH;
            end else begin
              state <= S_PRE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RD_ISSUE: begin
          cnt   <= '0;
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (RX_BURST_DETECT) begin
            PASS_TAP <= TAP_COUNT;
            state    <= S_FINISH;
          end else if (cnt == READ_LAST) begin
            cnt <= '0;
            if (TAP_COUNT == num_q) begin
              ERROR    <= 1'b1;
              ERR_CODE <= 2'b10;
              state    <= S_FINISH;
            end else begin
              DELAY_LINE_DIRECTION <= 1'b1;
              HS_IO_CLK_PAUSE      <= 1'b1;
              state                <= S_PRE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FINISH: begin
          DONE                 <= 1'b1;
          BUSY                 <= 1'b0;
          HS_IO_CLK_PAUSE      <= 1'b0;
          DELAY_LINE_SEL       <= 1'b0;
          DELAY_LINE_DIRECTION <= 1'b0;
          state                <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lane_dly_train_ctrl.md
Name: lane_dly_train_ctrl

Overview:
- Fabric-side initiator for the DDR4 lane controller's delay-line control interface.
- Drives DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION and DELAY_LINE_MOVE, brackets every tap change with HS_IO_CLK_PAUSE, and issues DDR_READ probes.
- Observes RX_BURST_DETECT and the RX/TX out-of-range flags.
- Two modes:
  - Direct: step N taps in a given direction.
  - Sweep: reset the RX DQS delay to tap 0, then step up until a read burst is detected. The passing tap is reported to the training sequencer.

Parameters:
- TAP_W, 8, width of tap counter and NUM_TAPS.
- SETTLE_CYCLES, 8, cycles PAUSE stays high after each MOVE/LOAD pulse (min 1).
- PRE_CYCLES, 2, cycles PAUSE is high before each MOVE/LOAD pulse (min 1).
- READ_WAIT, 16, cycles to wait for RX_BURST_DETECT after each DDR_READ probe.

Ports:
- FAB_CLK, in, 1, single clock for all logic.
- RESET, in, 1, asynchronous active-high reset.
- START, in, 1, one-cycle operation request; ignored while BUSY.
- MODE, in, 1: 0 = direct, 1 = sweep.
- SEL_IN, in, 1, delay line select latched at START (0 = RX DQS, 1 = TX DQS). Forced to 0 in sweep mode.
- DIR_IN, in, 1, direction latched at START (1 = increment); direct mode only.
- NUM_TAPS, in, TAP_W: step count in direct mode; last tap to try in sweep mode.
- RX_BURST_DETECT, in, 1, burst seen by the lane.
- RX_DELAY_LINE_OUT_OF_RANGE, in, 1, RX line limit flag.
- TX_DELAY_LINE_OUT_OF_RANGE, in, 1, TX line limit flag.
- DELAY_LINE_SEL, out, 1, to lane.
- DELAY_LINE_LOAD, out, 1, to lane; one-cycle pulse.
- DELAY_LINE_DIRECTION, out, 1, to lane.
- DELAY_LINE_MOVE, out, 1, to lane; one-cycle pulse.
- HS_IO_CLK_PAUSE, out, 1, to lane pause input.
- DDR_READ, out, 1, read probe; one-cycle pulse.
- BUSY, out, 1, operation in progress.
- DONE, out, 1, one-cycle completion pulse (success or error).
- ERROR, out, 1, sticky error; cleared by next accepted START.
- ERR_CODE, out, 2: 00 none, 01 out-of-range, 10 no pass found.
- TAP_COUNT, out, TAP_W, tracked tap position of the selected line.
- PASS_TAP, out, TAP_W, first passing tap from the last successful sweep.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. RESET asserted mid-operation aborts immediately: state returns to IDLE and no further pulses are emitted.
- States: IDLE, LOAD, PRE, MOVE, SETTLE, RD_ISSUE, RD_WAIT, FINISH.
- IDLE:
  - START=1 latches SEL/DIR/NUM_TAPS and clears ERROR/ERR_CODE.
  - BUSY=1 from the next cycle.
  - MODE=0 goes to PRE; MODE=1 goes to PRE with a load pending.
  - Direct mode with NUM_TAPS=0 goes straight to FINISH.
- PRE: HS_IO_CLK_PAUSE=1 for PRE_CYCLES, then go to LOAD if a load is pending, else to MOVE.
- LOAD: DELAY_LINE_LOAD=1 and PAUSE=1 for one cycle; TAP_COUNT<=0; then SETTLE.
- MOVE:
  - DELAY_LINE_MOVE=1, PAUSE=1, DIRECTION=latched DIR for one cycle.
  - TAP_COUNT +1/-1, saturating at 0 and at 2^TAP_W-1.
  - Then SETTLE.
- SETTLE:
  - PAUSE=1 for SETTLE_CYCLES.
  - On the last cycle, sample the out-of-range flag of the selected line. If set: ERROR=1, ERR_CODE=01, go to FINISH.
  - Otherwise:
    - Direct mode: if steps remaining is 0, go to FINISH; else go to PRE.
    - Sweep mode: go to RD_ISSUE.
- RD_ISSUE: DDR_READ=1 for one cycle; PAUSE=0.
- RD_WAIT:
  - Count up to READ_WAIT cycles.
  - RX_BURST_DETECT=1 on any cycle: PASS_TAP<=TAP_COUNT, go to FINISH.
  - Burst detect on the final timeout cycle counts as a pass.
  - On timeout with TAP_COUNT==NUM_TAPS: ERROR=1, ERR_CODE=10, go to FINISH.
  - On timeout otherwise: direction forced to increment, go to PRE.
- FINISH: DONE=1 for one cycle, BUSY=0 on the same edge, return to IDLE.
- DELAY_LINE_SEL and DIRECTION hold their latched values throughout the operation and return to 0 in IDLE.
- MOVE, LOAD and DDR_READ are never asserted in the same cycle.
- MOVE and LOAD are asserted only while PAUSE=1.
- Per-tap cost in direct mode: PRE_CYCLES+1+SETTLE_CYCLES (11 cycles at defaults).
- With START sampled at edge k, DONE is asserted at edge k+1+N*(PRE_CYCLES+1+SETTLE_CYCLES).
- START arriving while BUSY or during FINISH is dropped.

Test Plan:
- Direct mode, SEL_IN=0, DIR_IN=1, NUM_TAPS=3, defaults, START at edge 0 -> exactly 3 MOVE pulses; each MOVE preceded by 2 PAUSE cycles and followed by 8; DONE at edge 34; TAP_COUNT=3; ERROR=0.
- Direct mode with NUM_TAPS=0 -> DONE one cycle after START; no MOVE/LOAD/PAUSE activity; BUSY high for exactly 1 cycle.
- Sweep mode, NUM_TAPS=10, RX_BURST_DETECT driven 5 cycles after the fourth DDR_READ -> one LOAD pulse, 3 MOVEs, PASS_TAP=3, ERROR=0, DONE single pulse.
- Sweep mode, NUM_TAPS=2, burst never asserted -> 3 DDR_READ probes (taps 0, 1, 2); ERROR=1, ERR_CODE=10; DONE pulse; TAP_COUNT=2.
- Direct mode, SEL_IN=1, DIR_IN=0, NUM_TAPS=5, TX_DELAY_LINE_OUT_OF_RANGE=1 during the second SETTLE -> stops after 2 MOVEs; ERR_CODE=01; next START clears ERROR.
- RESET pulsed mid-SETTLE, and START asserted while BUSY -> all outputs 0 immediately on reset; no DONE; START during BUSY has no effect on NUM_TAPS or mode.
